uart_tx_fifo: RTL



---
 rtl/uart_pkg.sv | 24 ++
 rtl/sync_fifo.sv | 67 ++++++
 rtl/uart_tx_fifo.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit (and later receive) path.
package uart_pkg;

    // Serialiser states, in frame order.
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } tx_state_t;

    // Parity modes.
    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Length of one frame in clk cycles.
    function automatic int frame_len(input int data_bits, input int parity,
                                     input int stop_bits, input int clks_per_bit);
        return (1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits) * clks_per_bit;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with an occupancy counter; dout always shows the head entry
// so the consumer can pop and use the word in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      level_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (level_reg == (AW+1)'(DEPTH));
    assign empty   = (level_reg == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem_reg[rd_ptr_reg];
    assign level   = level_reg;

    // Storage: each entry captures din when the write pointer selects it.
    // Contents are not reset; clearing the pointers discards them.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
            always_ff @(posedge clk) begin
                if (push_ok && (wr_ptr_reg == AW'(gi))) begin
                    mem_reg[gi] <= din;
                end
            end
        end
    endgenerate

    // Pointers wrap naturally at DEPTH; the counter separates full from empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a FIFO. Bit timing comes from a clock-enable style
// counter in the clk domain; the frame format is set by parameters.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 100000000 / 115200,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_BITS-1:0]          s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

    tx_state_t              state_reg;
    tx_state_t              state_next;
    logic [CW-1:0]          cnt_reg;
    logic [3:0]             idx_reg;
    logic [DATA_BITS-1:0]   shift_reg;
    logic                   par_reg;
    logic                   tx_reg;
    logic                   tx_next;
    logic                   bit_done;
    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [DATA_BITS-1:0]   fifo_dout;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (s_valid),
        .pop   (fifo_pop),
        .din   (s_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign bit_done = (cnt_reg == CNT_LAST);
    assign s_ready  = !fifo_full;
    assign busy     = !fifo_empty || (state_reg != S_IDLE);
    assign tx       = tx_reg;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: each non-idle state lasts whole bit times.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (!fifo_empty) state_next = S_START;
            end
            S_START: begin
                if (bit_done) state_next = S_DATA;
            end
            S_DATA: begin
                if (bit_done && (idx_reg == DATA_LAST)) begin
                    state_next = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (bit_done) state_next = S_STOP;
            end
            S_STOP: begin
                if (bit_done && (idx_reg == STOP_LAST)) begin
                    state_next = fifo_empty ? S_IDLE : S_START;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs: line level for the current state and the FIFO pop strobe,
    // which fires whenever a new frame is about to start.
    always_comb begin
        tx_next  = 1'b1;
        fifo_pop = 1'b0;
        case (state_reg)
            S_IDLE: begin
                tx_next  = 1'b1;
                fifo_pop = !fifo_empty;
            end
            S_START:  tx_next = 1'b0;
            S_DATA:   tx_next = shift_reg[0];
            S_PARITY: tx_next = par_reg;
            S_STOP: begin
                tx_next  = 1'b1;
                fifo_pop = bit_done && (idx_reg == STOP_LAST) && !fifo_empty;
            end
            default:  tx_next = 1'b1;
        endcase
    end

    // Datapath: bit timer, bit index, shift register, parity and the
    // registered line driver. Loading a word restarts the timer so every
    // bit of the new frame is exactly CLKS_PER_BIT cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg   <= '0;
            idx_reg   <= '0;
            shift_reg <= '0;
            par_reg   <= 1'b0;
            tx_reg    <= 1'b1;
        end else begin
            tx_reg <= tx_next;
            if (fifo_pop) begin
                cnt_reg   <= '0;
                idx_reg   <= '0;
                shift_reg <= fifo_dout;
                par_reg   <= (PARITY == PAR_ODD) ? ~^fifo_dout : ^fifo_dout;
            end else if (state_reg == S_IDLE) begin
                cnt_reg <= '0;
                idx_reg <= '0;
            end else if (bit_done) begin
                cnt_reg <= '0;
                if (state_reg == S_DATA) begin
                    shift_reg <= shift_reg >> 1;
                end
                if (state_next != state_reg) begin
                    idx_reg <= '0;
                end else begin
                    idx_reg <= idx_reg + 4'd1;
                end
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

endmodule
